// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, instruction field
// positions and the IF/ID buffer occupancy encoding.
package cpu_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int PC_WIDTH   = 16;
    localparam int IMM_SIZE   = 8;

    // Field MSBs for the default 16-bit instruction word
    localparam int OPC_MSB = 15;
    localparam int RD_MSB  = 11;
    localparam int RS_MSB  = 7;
    localparam int RT_MSB  = 3;

    // Occupancy encoding: {skid valid, main valid}
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b11;

    function automatic logic [1:0] occ_state(
        input logic main_v,
        input logic skid_v
    );
        return {skid_v, main_v};
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// Generic two-entry valid/ready skid buffer with flush.
// in_ready_o is registered; main entry drives the output.
module skid_buffer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);
    import cpu_pkg::*;

    logic         main_v_q, main_v_d;
    logic         skid_v_q, skid_v_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         rdy_q, rdy_d;
    logic         in_fire;
    logic         out_fire;
    logic [1:0]   state;

    assign in_fire  = in_valid_i && rdy_q;
    assign out_fire = main_v_q && out_ready_i;
    assign state    = occ_state(main_v_q, skid_v_q);

    // Next-state: occupancy transitions, flush overrides everything
    always_comb begin
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        main_d   = main_q;
        skid_d   = skid_q;
        if (flush_i) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_v_d = 1'b1;
                        main_d   = in_data_i;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data_i;
                    end else if (in_fire) begin
                        skid_v_d = 1'b1;
                        skid_d   = in_data_i;
                    end else if (out_fire) begin
                        main_v_d = 1'b0;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_d   = skid_q;
                        skid_v_d = 1'b0;
                    end
                end
                default: begin
                    main_v_d = 1'b0;
                    skid_v_d = 1'b0;
                end
            endcase
        end
        rdy_d = occ_state(main_v_d, skid_v_d) != ST_FULL;
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
            rdy_q    <= 1'b1;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            rdy_q    <= rdy_d;
        end
    end

    assign in_ready_o  = rdy_q;
    assign out_valid_o = main_v_q;
    assign out_data_o  = main_q;

endmodule

// File: rtl/if_id_stage.sv
// IF/ID stage: buffers fetched (pc, instr) pairs and slices the
// head instruction into opcode, register and raw immediate fields.
module if_id_stage #(
    parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
    parameter int PC_WIDTH   = cpu_pkg::PC_WIDTH,
    parameter int IMM_SIZE   = cpu_pkg::IMM_SIZE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PC_WIDTH-1:0]   in_pc,
    input  logic [DATA_WIDTH-1:0] in_instr,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PC_WIDTH-1:0]   out_pc,
    output logic [3:0]            out_opcode,
    output logic [3:0]            out_rd,
    output logic [3:0]            out_rs,
    output logic [3:0]            out_rt,
    output logic [IMM_SIZE-1:0]   imm_raw
);
    import cpu_pkg::*;

    localparam int W    = PC_WIDTH + DATA_WIDTH;
    // Shift of the top-aligned fields relative to the default width
    localparam int SHFT = DATA_WIDTH - cpu_pkg::DATA_WIDTH;
    localparam int OPC  = OPC_MSB + SHFT;
    localparam int RD   = RD_MSB + SHFT;
    localparam int RS   = RS_MSB + SHFT;

    logic [W-1:0]          head;
    logic [DATA_WIDTH-1:0] instr;

    skid_buffer #(
        .W (W)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   ({in_pc, in_instr}),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (head)
    );

    assign out_pc     = head[W-1 -: PC_WIDTH];
    assign instr      = head[DATA_WIDTH-1:0];
    assign out_opcode = instr[OPC -: 4];
    assign out_rd     = instr[RD -: 4];
    assign out_rs     = instr[RS -: 4];
    assign out_rt     = instr[RT_MSB -: 4];
    assign imm_raw    = instr[IMM_SIZE-1:0];

endmodule

// File: doc/if_id_stage.md
# if_id_stage

IF/ID pipeline stage between instruction fetch and decode. It accepts fetched (pc, instruction) pairs over a valid/ready handshake and buffers them in a two-entry skid buffer, so `in_ready` is a registered output. It splits the held instruction into opcode, register and immediate fields. `imm_raw` drives the `in` port of the downstream `SignExt`, which is instantiated with `IN_SIZE = IMM_SIZE` and `OUT_SIZE = DATA_WIDTH`.

## Interface
Parameters:
- `DATA_WIDTH`, 16, instruction width and `SignExt` output width
- `PC_WIDTH`, 16, program-counter width
- `IMM_SIZE`, 8, immediate field width; must be ≤ `DATA_WIDTH - 8`

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `in_valid` in 1: fetch presents a pair
- `in_ready` out 1: stage can accept; registered
- `in_pc` in `PC_WIDTH`: fetched PC
- `in_instr` in `DATA_WIDTH`: fetched instruction
- `flush` in 1: discard all held and incoming entries (branch taken)
- `out_valid` out 1: head entry valid
- `out_ready` in 1: decode consumes the head entry
- `out_pc` out `PC_WIDTH`: head PC
- `out_opcode` out 4: bits `[DATA_WIDTH-1 -: 4]`
- `out_rd` out 4: bits `[DATA_WIDTH-5 -: 4]`
- `out_rs` out 4: bits `[DATA_WIDTH-9 -: 4]`
- `out_rt` out 4: bits `[3:0]`
- `imm_raw` out `IMM_SIZE`: bits `[IMM_SIZE-1:0]`; to `SignExt.in`

## Operation
- Storage is two entries: `main` (head, drives outputs) and `skid`, each holding valid, pc and instr.
- Transfer rules:
  - Input transfer occurs when `in_valid && in_ready`.
  - Output transfer occurs when `out_valid && out_ready`.
- States, encoded by occupancy:
  - EMPTY: `main` invalid, `skid` invalid.
  - ONE: `main` valid, `skid` invalid.
  - FULL: both valid.
- Transitions:
  - EMPTY + in → ONE. The entry loads into `main`.
  - ONE + in, no out → FULL. The entry loads into `skid`.
  - ONE + in + out → ONE. `main` is replaced by the new entry.
  - ONE + out, no in → EMPTY.
  - FULL + out → ONE. `skid` moves to `main`. No input is possible in FULL because `in_ready` is 0.
- `in_ready` is registered and equals 1 exactly when the next state is not FULL.
- `flush` has priority over every other event:
  - Next state is EMPTY, both valid bits clear, `in_ready` becomes 1.
  - An input offered in the same cycle is dropped.
  - An output transfer in the same cycle still counts as consumed by decode.
- Field outputs are pure slices of `main.instr`. When `out_valid` is 0 they hold the last `main` contents.
- No arithmetic is done here. Sign extension belongs to `SignExt`.

## Timing
- Reset values while `rst_n` is low, applied immediately (asynchronous):
  - `out_valid` = 0, `in_ready` = 1.
  - `out_pc`, `out_opcode`, `out_rd`, `out_rs`, `out_rt`, `imm_raw` all = 0 (stored pc/instr cleared).
- Latency: an entry accepted at edge N is visible with `out_valid` = 1 after edge N. Minimum in-to-out is 1 cycle.
- Throughput: one entry per cycle when `out_ready` is held at 1.
- Handshake rules:
  - `out_valid` and all data outputs stay stable while `out_valid && !out_ready`.
  - Upstream may hold `in_valid` high across cycles with `in_ready` = 0; no entry is lost or duplicated.
- Reset asserted mid-operation discards all entries. After release the stage behaves as a fresh reset.
- Backpressure:
  - `out_ready` low for one cycle with continuous input → FULL, `in_ready` = 0 on the next cycle.
  - Recovery to `in_ready` = 1 occurs one cycle after the first output transfer.

## Structure
- A shared `cpu_pkg` holds:
  - field-position constants: `OPC_MSB`, `RD_MSB`, `RS_MSB`, `RT_MSB`
  - default widths `DATA_WIDTH`, `PC_WIDTH`, `IMM_SIZE`
  - the state encoding localparams `ST_EMPTY`, `ST_ONE`, `ST_FULL`
- Natural sub-module: `skid_buffer`, a generic 2-entry valid/ready buffer of width `PC_WIDTH + DATA_WIDTH` with flush. `if_id_stage` wraps it and adds the field slicing.

## Test plan
- Reset: hold `rst_n` = 0 with `in_valid` = 1 → `out_valid` = 0, `in_ready` = 1, `imm_raw` = 0. After release the first entry appears one cycle later.
- Streaming: `out_ready` = 1; feed instructions 16'h1234, 16'h5A80 at pc 0 and 2 on consecutive cycles.
  - Outputs appear on consecutive cycles.
  - 16'h1234 gives `out_opcode` = 1, `rd` = 2, `rs` = 3, `rt` = 4, `imm_raw` = 8'h34.
  - 16'h5A80 gives `imm_raw` = 8'h80, which drives `SignExt` to 16'hFF80.
- Backpressure:
  - `out_ready` = 0 while three entries are offered → `in_ready` falls after two accepted. The third is held upstream.
  - Release `out_ready` → outputs appear in order pc 0, 2, 4.
- Flush in FULL with `in_valid` = 1 → next cycle `out_valid` = 0, `in_ready` = 1, and the offered entry never appears.
- Simultaneous in+out in ONE → the state stays ONE and `out_pc` updates to the new PC the next cycle.
- Reset pulse while FULL → `out_valid` clears without waiting for a clock edge, and no stale entry appears after release.
